// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard.
// Slot record layout and register-file constants.
package hazard_pkg;

    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request bundle into the hazard scoreboard.
// The ID stage is master; the scoreboard answers with hazard_stall.
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_uses_src2;
    logic              id_is_store;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_read;
    logic              hazard_stall;

    modport master (
        output id_valid, id_src1, id_src2, id_uses_src2,
        output id_is_store, id_dest, id_wb_en, id_mem_read,
        input  hazard_stall
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_uses_src2,
        input  id_is_store, id_dest, id_wb_en, id_mem_read,
        output hazard_stall
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against one in-flight writer slot.
// Register 0 never matches.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] r_i,
    input  slot_t             slot_i,
    output logic              hit_o
);

    assign hit_o = slot_i.valid
                 & slot_i.wb_en
                 & (slot_i.dest == r_i)
                 & (r_i != ZERO_REG);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector with EXE/MEM/WB writer record and stall counter.
// Define HAZARD_FORWARD_EN to stall only on load-use against EXE.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave id,
    input  logic               freeze,
    input  logic               flush,
    output logic [REG_AW-1:0]  exe_dest_q,
    output logic [REG_AW-1:0]  mem_dest_q,
    output logic [REG_AW-1:0]  wb_dest_q,
    output logic [CNT_W-1:0]   stall_cnt
);

    slot_t exe_q, exe_d;
    slot_t mem_q;
    slot_t wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_AW-1:0] src [3];
    logic [2:0] chk;
    logic [2:0] hit_exe;
    logic [2:0] hit_mem;
    logic need;
    logic stall;

    assign src[0] = id.id_src1;
    assign src[1] = id.id_src2;
    assign src[2] = id.id_dest;
    assign chk = {id.id_is_store, id.id_uses_src2, 1'b1};

    for (genvar i = 0; i < 3; i++) begin : g_src
        hazard_match u_exe (
            .r_i    (src[i]),
            .slot_i (exe_q),
            .hit_o  (hit_exe[i])
        );
        hazard_match u_mem (
            .r_i    (src[i]),
            .slot_i (mem_q),
            .hit_o  (hit_mem[i])
        );
    end

`ifdef HAZARD_FORWARD_EN
    // Only a load still in EXE outruns the forwarding paths.
    assign need = (|(chk & hit_exe)) & exe_q.is_load;
`else
    assign need = |(chk & (hit_exe | hit_mem));
`endif

    assign stall = id.id_valid & ~flush & need;
    assign id.hazard_stall = stall;

    always_comb begin
        exe_d = '0;
        if (id.id_valid && !flush && !stall) begin
            exe_d.valid   = 1'b1;
            exe_d.wb_en   = id.id_wb_en;
            exe_d.dest    = id.id_dest;
            exe_d.is_load = id.id_mem_read;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (!freeze) begin
            exe_q <= exe_d;
            mem_q <= exe_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    assign exe_dest_q = exe_q.dest;
    assign mem_dest_q = mem_q.dest;
    assign wb_dest_q  = wb_q.dest;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed check of hazard_scoreboard against a queue model.
// Counter width is shrunk so saturation is reached.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic freeze, flush;
    logic [REG_AW-1:0] exe_dest_q, mem_dest_q, wb_dest_q;
    logic [CW-1:0] stall_cnt;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id         (bus),
        .freeze     (freeze),
        .flush      (flush),
        .exe_dest_q (exe_dest_q),
        .mem_dest_q (mem_dest_q),
        .wb_dest_q  (wb_dest_q),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit we;
        int d;
        bit ld;
    } wr_t;

    wr_t pipe[$];
    int  m_cnt;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  last_stall;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        wr_t b = '{v: 0, we: 0, d: 0, ld: 0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
        m_cnt = 0;
    endfunction

    // A dependency is visible on a writer that is still ahead of the register file.
    function automatic bit model_stall(input bit v, input int s1, input int s2,
                                       input bit u2, input bit st, input int d,
                                       input bit fl);
        int regs[$];
        int depth;
        bit s = 0;
        if (!v || fl) return 0;
        regs.push_back(s1);
        if (u2) regs.push_back(s2);
        if (st) regs.push_back(d);
        depth = FWD ? 1 : 2;
        foreach (regs[k]) begin
            if (regs[k] == 0) continue;
            for (int j = 0; j < depth; j++) begin
                if (pipe[j].v && pipe[j].we && pipe[j].d == regs[k]
                    && (!FWD || pipe[j].ld))
                    s = 1;
            end
        end
        return s;
    endfunction

    task automatic cyc(input bit v, input int s1, input int s2, input bit u2,
                       input bit st, input int d, input bit we, input bit ld,
                       input bit fz, input bit fl);
        bit  e;
        wr_t n;
        @(negedge clk);
        bus.id_valid     = v;
        bus.id_src1      = REG_AW'(s1);
        bus.id_src2      = REG_AW'(s2);
        bus.id_uses_src2 = u2;
        bus.id_is_store  = st;
        bus.id_dest      = REG_AW'(d);
        bus.id_wb_en     = we;
        bus.id_mem_read  = ld;
        freeze = fz;
        flush  = fl;
        #1;
        e = model_stall(v, s1, s2, u2, st, d, fl);
        check("stall", 32'(bus.hazard_stall), 32'(e));
        check("cnt", 32'(stall_cnt), 32'(m_cnt));
        if (pipe[0].v) check("exe_dest", 32'(exe_dest_q), 32'(pipe[0].d));
        if (pipe[1].v) check("mem_dest", 32'(mem_dest_q), 32'(pipe[1].d));
        last_stall = bus.hazard_stall;
        @(posedge clk);
        if (!fz) begin
            if (!v || fl || e) n = '{v: 0, we: 0, d: 0, ld: 0};
            else n = '{v: 1, we: we, d: d, ld: ld};
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(bus.hazard_stall), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        check("rst_exe", 32'(exe_dest_q), 0);
        check("rst_mem", 32'(mem_dest_q), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int c0;

    initial begin
        rst_n = 1'b0;
        freeze = 0;
        flush = 0;
        bus.id_valid = 0;
        bus.id_src1 = '0;
        bus.id_src2 = '0;
        bus.id_uses_src2 = 0;
        bus.id_is_store = 0;
        bus.id_dest = '0;
        bus.id_wb_en = 0;
        bus.id_mem_read = 0;
        model_reset();
        #2;
        check("por_stall", 32'(bus.hazard_stall), 0);
        check("por_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw r5 ; add r6,r5,r1 held in ID while stalled
        cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        cyc(1, 5, 1, 1, 0, 6, 1, 0, 0, 0);
        check("lu_first", 32'(last_stall), 1);
        cyc(1, 5, 1, 1, 0, 6, 1, 0, 0, 0);
        check("lu_second", 32'(last_stall), FWD ? 0 : 1);
        if (!FWD) cyc(1, 5, 1, 1, 0, 6, 1, 0, 0, 0);
        check("lu_cnt", 32'(stall_cnt), FWD ? 1 : 2);
        repeat (3) nop();

        // add r5 ; sub r7,r5,r2
        c0 = m_cnt;
        cyc(1, 1, 2, 1, 0, 5, 1, 0, 0, 0);
        do cyc(1, 5, 2, 1, 0, 7, 1, 0, 0, 0); while (last_stall && m_cnt < c0 + 4);
        check("alu_stalls", 32'(m_cnt - c0), FWD ? 0 : 2);
        repeat (3) nop();

        // r0 never hazards; masked src2 ignored
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        check("r0", 32'(last_stall), 0);
        repeat (3) nop();
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        cyc(1, 1, 3, 0, 0, 4, 1, 0, 0, 0);
        check("src2_mask", 32'(last_stall), 0);
        repeat (3) nop();

        // lw r8 ; sw r8,0(r2)
        cyc(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
        cyc(1, 2, 0, 0, 1, 8, 0, 0, 0, 0);
        check("store_val", 32'(last_stall), 1);
        repeat (3) nop();

        // load-use held under freeze, then flushed
        cyc(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        c0 = int'(stall_cnt);
        repeat (3) begin
            cyc(1, 9, 0, 0, 0, 10, 1, 0, 1, 0);
            check("frz_stall", 32'(last_stall), 1);
            check("frz_exe", 32'(exe_dest_q), 9);
        end
        check("frz_cnt", 32'(stall_cnt), 32'(c0));
        cyc(1, 9, 0, 0, 0, 10, 1, 0, 0, 1);
        check("flush_stall", 32'(last_stall), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_mem", 32'(mem_dest_q), 9);
        repeat (3) nop();

        for (int i = 0; i < 1200; i++) begin
            if (i == 600) begin
                do_reset();
                cyc(1, 5, 0, 0, 0, 6, 1, 0, 0, 0);
                check("post_rst", 32'(last_stall), 0);
            end
            cyc($urandom_range(0, 99) < 85, $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                1'($urandom), $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 10);
        end
        check("cnt_sat", 32'(stall_cnt), CMAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
